// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: result-source select codes and
// the load funct3 encodings consumed by the load formatter.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_CSR = 2'd3
    } wb_sel_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

endpackage

// File: rtl/load_formatter.sv
// Combinational load-data formatter: picks the addressed byte/half out of the
// aligned memory word and sign- or zero-extends it to XLEN.
module load_formatter
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      addr_low,
    output logic [XLEN-1:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (addr_low)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase

        // addr_low[0] is ignored for halves; misaligned halves never reach here.
        half_sel = addr_low[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (ld_funct3)
            LB:      load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LBU:     load_data = {{(XLEN-8){1'b0}}, byte_sel};
            LH:      load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            LHU:     load_data = {{(XLEN-16){1'b0}}, half_sel};
            LW:      load_data = mem_rdata;
            default: load_data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage_reg.sv
// Writeback pipeline register: selects the result, holds it under register-file
// back-pressure, drives the register-file write port, forwarding tap and retire counter.
module wb_stage_reg
    import wb_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic              wb_en_in,
    input  logic [REG_AW-1:0] rd_in,
    input  logic [1:0]        wb_sel,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic [XLEN-1:0]   pc_plus4,
    input  logic [XLEN-1:0]   csr_rdata,
    input  logic [2:0]        ld_funct3,
    input  logic [1:0]        addr_low,
    input  logic              rf_ready,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_rd,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [XLEN-1:0]   fwd_data,
    output logic [CNT_W-1:0]  retire_count
);

    logic              wb_valid;
    logic              wb_en;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic [CNT_W-1:0]  retire_cnt;

    logic [XLEN-1:0]   load_data;
    logic [XLEN-1:0]   result;
    logic              capture;
    logic              retire;

    load_formatter #(.XLEN(XLEN)) u_load_formatter (
        .mem_rdata (mem_rdata),
        .ld_funct3 (ld_funct3),
        .addr_low  (addr_low),
        .load_data (load_data)
    );

    always_comb begin
        result = alu_result;
        case (wb_sel_e'(wb_sel))
            WB_ALU:  result = alu_result;
            WB_MEM:  result = load_data;
            WB_PC4:  result = pc_plus4;
            WB_CSR:  result = csr_rdata;
            default: result = alu_result;
        endcase
    end

    // Handshake: upstream transfers when in_valid & in_ready (flush vetoes the
    // capture only); the held entry retires when wb_valid & rf_ready. A retire
    // frees the slot in the same cycle, so a new entry can be captured on that edge.
    assign in_ready = !wb_valid || rf_ready;
    assign capture  = in_valid && in_ready && !flush;
    assign retire   = wb_valid && rf_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid   <= 1'b0;
            wb_en      <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            retire_cnt <= '0;
        end else begin
            if (capture) begin
                wb_valid <= 1'b1;
                wb_en    <= wb_en_in;
                wb_rd    <= rd_in;
                wb_data  <= result;
            end else if (retire) begin
                wb_valid <= 1'b0;
            end
            if (retire) begin
                retire_cnt <= retire_cnt + 1'b1;
            end
        end
    end

    assign rf_we        = wb_valid && wb_en && (wb_rd != '0);
    assign rf_rd        = wb_rd;
    assign rf_wdata     = wb_data;
    assign fwd_valid    = rf_we;
    assign fwd_rd       = wb_rd;
    assign fwd_data     = wb_data;
    assign retire_count = retire_cnt;

endmodule

// File: tb/tb_wb_stage_reg.sv
// Self-checking bench for wb_stage_reg: directed cases followed by randomized
// traffic, compared against a transaction-level model of the held entry.
module tb_wb_stage_reg;
    import wb_pkg::*;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;
    localparam int W      = 1 + REG_AW + XLEN;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              flush = 1'b0;
    logic              wb_en_in = 1'b0;
    logic [REG_AW-1:0] rd_in = '0;
    logic [1:0]        wb_sel = 2'd0;
    logic [XLEN-1:0]   alu_result = '0;
    logic [XLEN-1:0]   mem_rdata = '0;
    logic [XLEN-1:0]   pc_plus4 = '0;
    logic [XLEN-1:0]   csr_rdata = '0;
    logic [2:0]        ld_funct3 = 3'd0;
    logic [1:0]        addr_low = 2'd0;
    logic              rf_ready = 1'b0;
    logic              rf_we;
    logic [REG_AW-1:0] rf_rd;
    logic [XLEN-1:0]   rf_wdata;
    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_rd;
    logic [XLEN-1:0]   fwd_data;
    logic [CNT_W-1:0]  retire_count;

    int n_cmp = 0;
    int n_err = 0;

    // Model: entries accepted but not yet retired ({wb_en, rd, data}), and retire count.
    logic [W-1:0]     exp_q[$];
    logic [CNT_W-1:0] exp_cnt = '0;

    wb_stage_reg #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .flush        (flush),
        .wb_en_in     (wb_en_in),
        .rd_in        (rd_in),
        .wb_sel       (wb_sel),
        .alu_result   (alu_result),
        .mem_rdata    (mem_rdata),
        .pc_plus4     (pc_plus4),
        .csr_rdata    (csr_rdata),
        .ld_funct3    (ld_funct3),
        .addr_low     (addr_low),
        .rf_ready     (rf_ready),
        .rf_we        (rf_we),
        .rf_rd        (rf_rd),
        .rf_wdata     (rf_wdata),
        .fwd_valid    (fwd_valid),
        .fwd_rd       (fwd_rd),
        .fwd_data     (fwd_data),
        .retire_count (retire_count)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference result from the architectural rules, using shifts and masks.
    function automatic logic [XLEN-1:0] ref_result();
        logic [31:0] b;
        logic [31:0] h;
        case (wb_sel)
            2'd0: return alu_result;
            2'd2: return pc_plus4;
            2'd3: return csr_rdata;
            default: begin
                b = (mem_rdata >> (8 * addr_low)) & 32'hFF;
                h = (mem_rdata >> (16 * (addr_low / 2))) & 32'hFFFF;
                if (ld_funct3 == LB)  return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
                if (ld_funct3 == LBU) return b;
                if (ld_funct3 == LH)  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
                if (ld_funct3 == LHU) return h;
                return mem_rdata;
            end
        endcase
    endfunction

    task automatic check_outputs(input bit exp_ready);
        logic [W-1:0] e;
        bit           we;
        check("in_ready", in_ready, exp_ready);
        if (exp_q.size() != 0) begin
            e  = exp_q[0];
            we = e[W-1] && (e[W-2 -: REG_AW] != '0);
            check("rf_we", rf_we, we);
            check("fwd_valid", fwd_valid, we);
            check("rf_rd", rf_rd, e[W-2 -: REG_AW]);
            check("fwd_rd", fwd_rd, e[W-2 -: REG_AW]);
            check("rf_wdata", rf_wdata, e[XLEN-1:0]);
            check("fwd_data", fwd_data, e[XLEN-1:0]);
        end else begin
            check("rf_we_idle", rf_we, 1'b0);
            check("fwd_valid_idle", fwd_valid, 1'b0);
        end
        check("retire_count", retire_count, exp_cnt);
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge.
    // Called and returns at rising edge + 1.
    task automatic cycle();
        bit exp_ready;
        bit ret;
        bit acc;
        @(negedge clk);
        exp_ready = (exp_q.size() == 0) || rf_ready;
        check_outputs(exp_ready);
        @(posedge clk);
        ret = (exp_q.size() != 0) && rf_ready;
        acc = in_valid && exp_ready && !flush;
        if (ret) begin
            void'(exp_q.pop_front());
            exp_cnt = exp_cnt + 1'b1;
        end
        if (acc) exp_q.push_back({wb_en_in, rd_in, ref_result()});
        #1;
    endtask

    task automatic drive(input bit v, input bit fl, input bit en, input logic [REG_AW-1:0] rd,
                         input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] mem,
                         input logic [2:0] f3, input logic [1:0] al, input bit rfr);
        in_valid   = v;
        flush      = fl;
        wb_en_in   = en;
        rd_in      = rd;
        wb_sel     = sel;
        alu_result = alu;
        mem_rdata  = mem;
        ld_funct3  = f3;
        addr_low   = al;
        rf_ready   = rfr;
        pc_plus4   = 32'h0000_1004;
        csr_rdata  = 32'hC5C5_0001;
    endtask

    task automatic idle();
        drive(0, 0, 0, '0, 2'd0, '0, '0, 3'd0, 2'd0, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        exp_q.delete();
        exp_cnt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [CNT_W-1:0] cnt_before;

    initial begin
        do_reset();
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_rf_rd", rf_rd, '0);
        check("rst_rf_wdata", rf_wdata, '0);
        check("rst_fwd_data", fwd_data, '0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_retire_count", retire_count, '0);

        // 1: LB / LBU of the top byte
        drive(1, 0, 1, 5'd5, 2'd1, '0, 32'h80FF_1234, LB, 2'd3, 1);
        cycle();
        check("t1_lb_we", rf_we, 1'b1);
        check("t1_lb_rd", rf_rd, 5'd5);
        check("t1_lb_data", rf_wdata, 32'hFFFF_FF80);
        drive(1, 0, 1, 5'd5, 2'd1, '0, 32'h80FF_1234, LBU, 2'd3, 1);
        cycle();
        check("t1_lbu_data", rf_wdata, 32'h0000_0080);

        // 2: halves
        drive(1, 0, 1, 5'd7, 2'd1, '0, 32'h8001_7FFF, LHU, 2'd2, 1);
        cycle();
        check("t2_lhu_data", rf_wdata, 32'h0000_8001);
        drive(1, 0, 1, 5'd7, 2'd1, '0, 32'h8001_7FFF, LH, 2'd0, 1);
        cycle();
        check("t2_lh_data", rf_wdata, 32'h0000_7FFF);
        idle();
        cycle();

        // 3: write to x0 is suppressed but still retires
        cnt_before = exp_cnt;
        drive(1, 0, 1, 5'd0, 2'd0, 32'hDEAD_BEEF, '0, LW, 2'd0, 1);
        cycle();
        check("t3_rf_we", rf_we, 1'b0);
        check("t3_fwd_valid", fwd_valid, 1'b0);
        idle();
        cycle();
        check("t3_cnt", retire_count, cnt_before + 1'b1);

        // 4: three cycles of back-pressure, then retire + capture on one edge
        drive(1, 0, 1, 5'd9, 2'd0, 32'hAAAA_0009, '0, LW, 2'd0, 1);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 5'd10, 2'd3, 32'h1, '0, LW, 2'd0, 0);
            cycle();
            check("t4_hold_ready", in_ready, 1'b0);
            check("t4_hold_data", rf_wdata, 32'hAAAA_0009);
        end
        drive(1, 0, 1, 5'd10, 2'd3, 32'h1, '0, LW, 2'd0, 1);
        cycle();
        check("t4_next_rd", rf_rd, 5'd10);
        check("t4_next_data", rf_wdata, 32'hC5C5_0001);
        idle();
        cycle();

        // 5: flush while an entry is held
        drive(1, 0, 1, 5'd11, 2'd2, '0, '0, LW, 2'd0, 1);
        cycle();
        drive(1, 1, 1, 5'd12, 2'd0, 32'h5555_5555, '0, LW, 2'd0, 1);
        cycle();
        check("t5_flushed_we", rf_we, 1'b0);
        idle();
        cycle();

        // reset while an entry is held under back-pressure
        drive(1, 0, 1, 5'd13, 2'd0, 32'h1357_9BDF, '0, LW, 2'd0, 1);
        cycle();
        rf_ready = 1'b0;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_we", rf_we, 1'b0);
        check("rst_mid_rd", rf_rd, '0);
        check("rst_mid_data", rf_wdata, '0);
        check("rst_mid_fwd_valid", fwd_valid, 1'b0);
        check("rst_mid_cnt", retire_count, '0);
        do_reset();
        for (int i = 0; i < 3; i++) cycle();

        // 6: 17 retires on a 4-bit counter
        for (int i = 0; i < 17; i++) begin
            drive(1, 0, 1, 5'($urandom_range(1, 31)), 2'd0, $urandom, '0, LW, 2'd0, 1);
            cycle();
        end
        idle();
        cycle();
        check("t6_cnt_wrap", retire_count, 4'd1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 7) == 0);
            wb_en_in   = ($urandom_range(0, 4) != 0);
            rd_in      = ($urandom_range(0, 3) == 0) ? '0 : 5'($urandom_range(1, 31));
            wb_sel     = 2'($urandom_range(0, 3));
            alu_result = $urandom;
            mem_rdata  = $urandom;
            pc_plus4   = $urandom;
            csr_rdata  = $urandom;
            ld_funct3  = 3'($urandom_range(0, 7));
            addr_low   = 2'($urandom_range(0, 3));
            rf_ready   = ($urandom_range(0, 2) != 0);
            cycle();
        end
        idle();
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
